relu_cell: RTL and testbench



---
 rtl/relu_cell.sv | 99 +++++++++
 tb/tb_relu_cell.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/relu_cell.sv
// ---------------------------------------------------------------------------
// relu_cell
//
// Output stage of a processing-cell chain. Each cycle it may receive one
// signed accumulator result, applies ReLU (negative -> 0), narrows the
// result to DATA_WIDTH bits and tags it with a cyclic cell index
// 0 .. CELL_AMOUNT-1. Every output is a flop, so latency is exactly one
// cycle and there is no combinational input-to-output path.
//
// Optional feature macro: RELU_CELL_SATURATE_EN
//   defined   : positive results above 2^DATA_WIDTH-1 clamp to all ones
//   undefined : positive results are truncated to their low DATA_WIDTH bits
//   Negative results give 0 either way; timing and indexing are unaffected.
//
// Ports:
//   clk            in   1               rising-edge clock
//   rst_n          in   1               asynchronous, active-low reset
//   input_result   in   RESULT_WIDTH+1  [RESULT_WIDTH] = valid,
//                                       [RESULT_WIDTH-1:0] = signed result
//   output_index   out  DATA_WIDTH      cell index of the current output
//   output_value   out  DATA_WIDTH      ReLU-ed, narrowed value
//   output_enable  out  1               output valid strobe
//
// Handshake: valid-only. A result is accepted on every edge where its valid
// bit is 1 (there is no ready / back-pressure); output_enable marks the
// cycle in which the matching output is presented, one cycle later.
// ---------------------------------------------------------------------------
module relu_cell #(
    parameter int DATA_WIDTH   = 32,
    parameter int RESULT_WIDTH = 64,
    parameter int CELL_AMOUNT  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [RESULT_WIDTH:0]   input_result,
    output logic [DATA_WIDTH-1:0]   output_index,
    output logic [DATA_WIDTH-1:0]   output_value,
    output logic                    output_enable
);

`ifdef RELU_CELL_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    // Working width wide enough for either the result or the output, so the
    // narrowing logic works whether RESULT_WIDTH is larger or smaller.
    localparam int EXT_W = (RESULT_WIDTH > DATA_WIDTH) ? RESULT_WIDTH : DATA_WIDTH;

    localparam logic [DATA_WIDTH-1:0] LAST_IDX = DATA_WIDTH'(CELL_AMOUNT - 1);

    logic                    w_valid;
    logic                    w_negative;
    logic [EXT_W-1:0]        w_mag;
    logic                    w_over;
    logic [DATA_WIDTH-1:0]   w_narrow;
    logic [DATA_WIDTH-1:0]   w_relu;

    logic [DATA_WIDTH-1:0]   r_idx;
    logic [DATA_WIDTH-1:0]   r_index;
    logic [DATA_WIDTH-1:0]   r_value;
    logic                    r_enable;

    assign w_valid    = input_result[RESULT_WIDTH];
    assign w_negative = input_result[RESULT_WIDTH-1];

    // Zero-extension is safe: the magnitude is only used when the result is
    // non-negative, in which case the sign bit is already 0.
    assign w_mag    = EXT_W'(input_result[RESULT_WIDTH-1:0]);
    assign w_over   = |(w_mag >> DATA_WIDTH);
    assign w_narrow = (SATURATE && w_over) ? {DATA_WIDTH{1'b1}} : w_mag[DATA_WIDTH-1:0];
    assign w_relu   = w_negative ? '0 : w_narrow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_index  <= '0;
            r_value  <= '0;
            r_enable <= 1'b0;
        end else if (w_valid) begin
            r_enable <= 1'b1;
            r_index  <= r_idx;
            r_value  <= w_relu;
            r_idx    <= (r_idx == LAST_IDX) ? '0 : r_idx + DATA_WIDTH'(1);
        end else begin
            // Idle cycle: outputs clear, but the cell position is kept so the
            // next valid result continues the rotation.
            r_enable <= 1'b0;
            r_index  <= '0;
            r_value  <= '0;
        end
    end

    assign output_index  = r_index;
    assign output_value  = r_value;
    assign output_enable = r_enable;

endmodule

// File: tb/tb_relu_cell.sv
module tb_relu_cell;

  localparam int DW = 32;
  localparam int RW = 64;
  localparam int CA = 2;
  localparam int EW = 1 + DW + DW;

  logic          clk;
  logic          rst_n;
  logic [RW:0]   input_result;
  logic [DW-1:0] output_index;
  logic [DW-1:0] output_value;
  logic          output_enable;

  int checks   = 0;
  int failures = 0;

  // expected {enable, index, value}, one entry per driven cycle
  logic [EW-1:0] exp_q[$];
  int unsigned   m_count;

  relu_cell #(
    .DATA_WIDTH  (DW),
    .RESULT_WIDTH(RW),
    .CELL_AMOUNT (CA)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_result (input_result),
    .output_index (output_index),
    .output_value (output_value),
    .output_enable(output_enable)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Index = number of valid results since reset, modulo the cell count.
  function automatic logic [DW-1:0] model_value(input longint d);
    longint unsigned lim;
    lim = (64'd1 << DW) - 64'd1;
    if (d < 0) return '0;
`ifdef RELU_CELL_SATURATE_EN
    if (longint'(d) > longint'(lim)) return {DW{1'b1}};
`endif
    return DW'(longint'(d) & longint'(lim));
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit v, input longint d);
    logic [DW-1:0] ei;
    logic [DW-1:0] ev;
    @(negedge clk);
    #1;
    input_result = {v, d};
    if (v) begin
      ei = DW'(m_count % CA);
      ev = model_value(d);
      m_count++;
      exp_q.push_back({1'b1, ei, ev});
    end else begin
      exp_q.push_back({1'b0, {DW{1'b0}}, {DW{1'b0}}});
    end
  endtask

  // literal check taken just after the sampling edge
  task automatic pin(input string name, input logic [DW-1:0] ev,
                     input logic [DW-1:0] ei, input logic ee);
    checks++;
    if (output_value !== ev || output_index !== ei || output_enable !== ee) begin
      failures++;
      $display("FAIL %s: got value=%0h index=%0d enable=%0b, want value=%0h index=%0d enable=%0b",
               name, output_value, output_index, output_enable, ev, ei, ee);
    end
  endtask

  task automatic pin_after_edge(input string name, input logic [DW-1:0] ev,
                                input logic [DW-1:0] ei, input logic ee);
    @(posedge clk);
    #1;
    pin(name, ev, ei, ee);
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({output_enable, output_index, output_value} !== e) begin
        failures++;
        $display("FAIL cmp t=%0t: got en=%0b idx=%0d val=%0h, want en=%0b idx=%0d val=%0h",
                 $time, output_enable, output_index, output_value,
                 e[EW-1], e[2*DW-1:DW], e[DW-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    longint d;
    logic [DW-1:0] big_exp;
    rst_n        = 1'b0;
    input_result = '0;
    m_count      = 0;
    repeat (3) @(posedge clk);
    #1;
    pin("reset_state", 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // idle with data=1
    drive(1'b0, 64'd1);
    pin_after_edge("idle_after_reset", 32'd0, 32'd0, 1'b0);

    // 1, -1, -20, 15
    drive(1'b1, 64'd1);
    pin_after_edge("seq_1", 32'd1, 32'd0, 1'b1);
    drive(1'b1, -64'sd1);
    pin_after_edge("seq_m1", 32'd0, 32'd1, 1'b1);
    drive(1'b1, -64'sd20);
    pin_after_edge("seq_m20", 32'd0, 32'd0, 1'b1);
    drive(1'b1, 64'd15);
    pin_after_edge("seq_15", 32'd15, 32'd1, 1'b1);

    drive(1'b0, 64'd15);
    pin_after_edge("idle_15", 32'd0, 32'd0, 1'b0);
    drive(1'b1, 64'd7);
    pin_after_edge("wrap_7", 32'd7, 32'd0, 1'b1);

    // bring idx back to 0, then idle must hold position
    drive(1'b1, 64'd8);
    pin_after_edge("val_8", 32'd8, 32'd1, 1'b1);
    drive(1'b1, 64'd5);
    pin_after_edge("val_5", 32'd5, 32'd0, 1'b1);
    drive(1'b0, 64'd0);
    pin_after_edge("idle_hold", 32'd0, 32'd0, 1'b0);
    drive(1'b1, 64'd6);
    pin_after_edge("held_6", 32'd6, 32'd1, 1'b1);

    // overflow past DATA_WIDTH
`ifdef RELU_CELL_SATURATE_EN
    big_exp = 32'hFFFF_FFFF;
`else
    big_exp = 32'h0000_0000;
`endif
    drive(1'b1, 64'd1 << 40);
    pin_after_edge("big_2p40", big_exp, 32'd0, 1'b1);
    drive(1'b1, 64'h0000_0000_FFFF_FFFF);
    pin_after_edge("max_fit", 32'hFFFF_FFFF, 32'd1, 1'b1);
    drive(1'b1, 64'd0);
    pin_after_edge("zero", 32'd0, 32'd0, 1'b1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0: d = -longint'($urandom_range(1, 1000));
        1: d = longint'($urandom_range(0, 1000));
        2: d = {$urandom, $urandom};
        3: d = 64'h0000_0000_FFFF_FFFF + longint'($urandom_range(0, 2)) - 1;
        4: d = {1'b0, 31'($urandom), $urandom};
        default: d = longint'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, d);
    end

    // asynchronous reset mid-stream
    drive(1'b1, 64'd9);
    @(posedge clk);
    #1;
    checks++;
    if (output_enable !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_enable: got %0b want 1", output_enable);
    end
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    m_count = 0;
    input_result = '0;
    #1;
    pin("async_reset", 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 64'd3);
    pin_after_edge("after_reset_3", 32'd3, 32'd0, 1'b1);
    drive(1'b1, 64'd4);
    pin_after_edge("after_reset_4", 32'd4, 32'd1, 1'b1);
    drive(1'b0, 64'd0);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
